// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator with two circular line buffers, feeding the pe x input.
// Optional build macro CONV_WIN_STRIDE2_EN: emit only windows whose top-left corner is at an even row and even column.
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_vld_i,
  input  logic [DW-1:0]   pix_i,
  output logic [9*DW-1:0] win_o,
  output logic            win_vld_o,
  output logic            frame_done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];

  logic [DW-1:0] top [3];
  logic [DW-1:0] mid [3];
  logic [DW-1:0] bot [3];

  logic [DW-1:0]   lb0_rd_p0;
  logic [DW-1:0]   lb1_rd_p0;
  logic            col_last_p0;
  logic            row_last_p0;
  logic            emit_base_p0;
  logic            emit_p0;
  logic [9*DW-1:0] win_p0;

  // Stage p0: read-before-write line buffer taps and window qualification
  assign lb0_rd_p0    = lb0[col];
  assign lb1_rd_p0    = lb1[col];
  assign col_last_p0  = (col == COL_LAST);
  assign row_last_p0  = (row == ROW_LAST);
  assign emit_base_p0 = (row >= ROW_TWO) && (col >= COL_TWO);

`ifdef CONV_WIN_STRIDE2_EN
  // row-2 and col-2 even is the same as row and col even
  assign emit_p0 = emit_base_p0 && !row[0] && !col[0];
`else
  assign emit_p0 = emit_base_p0;
`endif

  assign win_p0 = {top[1], top[2], lb0_rd_p0,
                   mid[1], mid[2], lb1_rd_p0,
                   bot[1], bot[2], pix_i};

  // Line buffers carry no reset; rows 0-1 of every frame overwrite them before use
  always_ff @(posedge clk) begin
    if (rst_n && pix_vld_i) begin
      lb0[col] <= lb1_rd_p0;
      lb1[col] <= pix_i;
    end
  end

  // Stage p0 -> p1: registered window, strobes and raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      win_vld_o    <= 1'b0;
      frame_done_o <= 1'b0;
      win_o        <= '0;
      for (int i = 0; i < 3; i++) begin
        top[i] <= '0;
        mid[i] <= '0;
        bot[i] <= '0;
      end
    end else begin
      win_vld_o    <= pix_vld_i && emit_p0;
      frame_done_o <= pix_vld_i && col_last_p0 && row_last_p0;
      if (pix_vld_i) begin
        top[0] <= top[1];
        top[1] <= top[2];
        top[2] <= lb0_rd_p0;
        mid[0] <= mid[1];
        mid[1] <= mid[2];
        mid[2] <= lb1_rd_p0;
        bot[0] <= bot[1];
        bot[1] <= bot[2];
        bot[2] <= pix_i;
        if (emit_p0) begin
          win_o <= win_p0;
        end
        if (col_last_p0) begin
          col <= '0;
          row <= row_last_p0 ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a small frame instance and a 28x28 instance against a frame-array model.
module tb_conv_window_gen;

`ifdef CONV_WIN_STRIDE2_EN
  localparam int SW = 6;
  localparam bit STRIDE2 = 1'b1;
  localparam logic [71:0] LAST_WIN = {8'd15, 8'd16, 8'd17, 8'd21, 8'd22, 8'd23, 8'd27, 8'd28, 8'd29};
`else
  localparam int SW = 4;
  localparam bit STRIDE2 = 1'b0;
  localparam logic [71:0] LAST_WIN = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
`endif
  localparam int SH = SW;
  localparam int BW = 28;
  localparam int BH = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst_n, s_vld, s_wv, s_done;
  logic [7:0]  s_pix;
  logic [71:0] s_win;
  logic        b_rst_n, b_vld, b_wv, b_done;
  logic [7:0]  b_pix;
  logic [71:0] b_win;

  conv_window_gen #(.IMG_W(SW), .IMG_H(SH), .DW(8)) u_small (
    .clk(clk), .rst_n(s_rst_n), .pix_vld_i(s_vld), .pix_i(s_pix),
    .win_o(s_win), .win_vld_o(s_wv), .frame_done_o(s_done));

  conv_window_gen #(.IMG_W(BW), .IMG_H(BH), .DW(8)) u_big (
    .clk(clk), .rst_n(b_rst_n), .pix_vld_i(b_vld), .pix_i(b_pix),
    .win_o(b_win), .win_vld_o(b_wv), .frame_done_o(b_done));

  typedef struct {
    logic        vld;
    logic [71:0] win;
    logic        done;
    time         due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;
  int nwin_s = 0;
  int nwin_b = 0;

  logic [7:0]  img [0:1][0:27][0:27];
  int          mr [0:1];
  int          mc [0:1];
  logic [71:0] mwin [0:1];

  function automatic bit qualifies(input int r, input int c);
    if (r < 2 || c < 2) return 1'b0;
    if (STRIDE2) return ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
    return 1'b1;
  endfunction

  function automatic int wins_per_frame(input int h, input int w);
    if (STRIDE2) return ((h - 1) / 2) * ((w - 1) / 2);
    return (h - 2) * (w - 2);
  endfunction

  task automatic model_reset(input int sel);
    mr[sel] = 0;
    mc[sel] = 0;
    mwin[sel] = '0;
  endtask

  // Store the pixel in the frame image; the window is read straight out of the 2D frame
  task automatic model_accept(input int sel, input logic [7:0] p);
    int w, h, r, c;
    bit q, last;
    exp_t e;
    logic [71:0] win;
    w = (sel == 0) ? SW : BW;
    h = (sel == 0) ? SH : BH;
    r = mr[sel];
    c = mc[sel];
    img[sel][r][c] = p;
    q = qualifies(r, c);
    last = (r == h - 1) && (c == w - 1);
    if (q) begin
      win = '0;
      for (int k = 0; k < 9; k++)
        win[(8 - k) * 8 +: 8] = img[sel][r - 2 + k / 3][c - 2 + k % 3];
      mwin[sel] = win;
    end
    if (q || last) begin
      e.vld = q;
      e.win = mwin[sel];
      e.done = last;
      e.due = $time + 5;
      if (sel == 0) q_s.push_back(e);
      else q_b.push_back(e);
    end
    c++;
    if (c == w) begin
      c = 0;
      r++;
      if (r == h) r = 0;
    end
    mr[sel] = r;
    mc[sel] = c;
  endtask

  task automatic check_one(input int sel, input logic v, input logic d, input logic [71:0] w);
    exp_t e;
    bit have;
    have = 1'b0;
    if (sel == 0) begin
      while (q_s.size() > 0 && q_s[0].due < $time) begin
        void'(q_s.pop_front());
        checks++; errors++;
        $display("FAIL stale_expect dut=%0d window never presented at t=%0t", sel, $time);
      end
      if (q_s.size() > 0 && q_s[0].due == $time) begin e = q_s.pop_front(); have = 1'b1; end
    end else begin
      while (q_b.size() > 0 && q_b[0].due < $time) begin
        void'(q_b.pop_front());
        checks++; errors++;
        $display("FAIL stale_expect dut=%0d window never presented at t=%0t", sel, $time);
      end
      if (q_b.size() > 0 && q_b[0].due == $time) begin e = q_b.pop_front(); have = 1'b1; end
    end
    if (have) begin
      checks++;
      if (v !== e.vld || d !== e.done || w !== e.win) begin
        errors++;
        $display("FAIL window dut=%0d t=%0t got vld=%b done=%b win=%h expected vld=%b done=%b win=%h",
                 sel, $time, v, d, w, e.vld, e.done, e.win);
      end else if (v) begin
        if (sel == 0) nwin_s++;
        else nwin_b++;
      end
    end else if (v !== 1'b0 || d !== 1'b0) begin
      checks++; errors++;
      $display("FAIL unexpected_output dut=%0d t=%0t got vld=%b done=%b expected vld=0 done=0", sel, $time, v, d);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      check_one(0, s_wv, s_done, s_win);
      check_one(1, b_wv, b_done, b_win);
    end
  endtask

  task automatic check_zero(input int sel);
    logic [71:0] w;
    logic v, d;
    w = (sel == 0) ? s_win : b_win;
    v = (sel == 0) ? s_wv : b_wv;
    d = (sel == 0) ? s_done : b_done;
    checks++;
    if (w !== '0 || v !== 1'b0 || d !== 1'b0) begin
      errors++;
      $display("FAIL reset_state dut=%0d got win=%h vld=%b done=%b expected all 0", sel, w, v, d);
    end
  endtask

  task automatic check_count(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  // Called at posedge+1; the pixel is accepted at the following posedge
  task automatic drive(input int sel, input logic v, input logic [7:0] p);
    if (sel == 0) begin s_vld = v; s_pix = p; end
    else begin b_vld = v; b_pix = p; end
    @(posedge clk);
    if (v) model_accept(sel, p);
    #1;
    if (sel == 0) s_vld = 1'b0;
    else b_vld = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic small_frame(input int base);
    for (int i = 1; i <= SW * SH; i++) drive(0, 1'b1, 8'(base + i));
  endtask

  initial begin
    int nws, nwb, bound;
    nws = wins_per_frame(SH, SW);
    nwb = wins_per_frame(BH, BW);
    s_rst_n = 1'b0; b_rst_n = 1'b0;
    s_vld = 1'b0; b_vld = 1'b0;
    s_pix = '0; b_pix = '0;
    model_reset(0);
    model_reset(1);
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    s_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    check_zero(0);
    check_zero(1);
    @(posedge clk); #1;

    small_frame(0);
    repeat (3) idle();
    check_count("basic_windows", nwin_s, nws);
    checks++;
    if (s_win !== LAST_WIN) begin
      errors++;
      $display("FAIL basic_last_window_hold got %h expected %h", s_win, LAST_WIN);
    end

    for (int i = 1; i <= SW * SH; i++) begin
      while ($urandom_range(1, 0) == 1) idle();
      drive(0, 1'b1, 8'(i));
    end
    repeat (3) idle();
    check_count("bubble_windows", nwin_s, 2 * nws);

    small_frame(0);
    small_frame(100);
    repeat (3) idle();
    check_count("b2b_windows", nwin_s, 4 * nws);

    for (int i = 1; i <= 10; i++) drive(0, 1'b1, 8'(i));
    s_rst_n = 1'b0; s_vld = 1'b1; s_pix = 8'd99;
    @(posedge clk);
    model_reset(0);
    #1;
    s_rst_n = 1'b1; s_vld = 1'b0;
    @(negedge clk);
    check_zero(0);
    @(posedge clk); #1;
    small_frame(0);
    repeat (3) idle();
    check_count("post_reset_windows", nwin_s, 5 * nws);

    for (int i = 0; i < BW * BH; i++) begin
      if ($urandom_range(7, 0) == 0) idle();
      drive(1, 1'b1, (i % 37 == 0) ? 8'hFF : 8'($urandom));
    end

    bound = 0;
    while ((q_s.size() > 0 || q_b.size() > 0) && bound < 20) begin
      idle();
      bound++;
    end
    checks++;
    if (q_s.size() > 0 || q_b.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending small=%0d big=%0d expected 0", q_s.size(), q_b.size());
    end
    repeat (2) idle();
    check_count("big_frame_windows", nwin_b, nwb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that sits directly upstream of the `pe` convolution element. It accepts an 8-bit image in raster order, one pixel per accepted cycle, and buffers two full image rows. For every valid output position it presents a 72-bit window in the exact packing `pe` expects on its `x` input, with a one-cycle valid strobe. There is no backpressure: the consumer must take every window in the cycle it is offered.

## Interface
Parameters:
- `IMG_W`, default 28: image width in pixels (≥3).
- `IMG_H`, default 28: image height in pixels (≥3).
- `DW`, default 8: pixel width. The window output is 9*DW bits.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `pix_vld_i`, input, 1: pixel valid. The pixel is accepted on any clk edge where this is high.
- `pix_i`, input, DW: pixel value, unsigned.
- `win_o`, output, 9*DW: window.
  - x00 occupies `[9*DW-1 -: DW]`, down to x22 at `[DW-1:0]`.
  - Order is x00,x01,x02,x10,x11,x12,x20,x21,x22.
  - xR C = pixel at (row−2+R, col−2+C) relative to the current pixel.
- `win_vld_o`, output, 1: `win_o` is valid this cycle.
- `frame_done_o`, output, 1: one-cycle pulse, coincident with the last window of a frame.

## Operation
- **Counters.**
  - `col` runs 0..IMG_W−1 and `row` runs 0..IMG_H−1. Both advance only on accepted pixels.
  - `col` wraps to 0 at IMG_W−1 and increments `row`.
  - At (IMG_H−1, IMG_W−1) both wrap to 0, and the next pixel starts a new frame. No idle cycle is required between frames.
- **Line buffers.**
  - Two circular buffers, each IMG_W×DW, indexed by `col`.
  - On each accept: `lb1[col]` is written to `lb0[col]`, and `pix_i` is written to `lb1[col]`.
  - The read-before-write value is used for the current column: old `lb0[col]` is the row−2 pixel, and old `lb1[col]` is the row−1 pixel.
- **Shift window.**
  - There are three 3-deep column shift registers: top, mid, bottom.
  - On accept, each shifts left by one. The new column is {old `lb0[col]`, old `lb1[col]`, `pix_i`}.
  - Contents persist when `pix_vld_i` is low.
- **Valid rule.** A window is emitted for an accepted pixel at (row, col) when row ≥ 2 and col ≥ 2. This is valid padding: (IMG_H−2)*(IMG_W−2) windows per frame.
- **Column wrap.** Windows never straddle a row wrap, because col < 2 suppresses valid. Stale shift contents are therefore harmless.
- **Line buffer contents.** Not cleared by reset or at frame start. Rows 0–1 never produce windows, so stale data is never exposed.
- **Reset mid-frame.** `row`, `col`, `win_vld_o` and `frame_done_o` all go to 0. The next accepted pixel is treated as (0,0).
- **Width rule.** No arithmetic on pixel data; pixels are passed through bit-exact.

## Timing
- Reset values:
  - `win_vld_o` = 0, `frame_done_o` = 0.
  - `win_o` = 0, with the shift registers cleared.
  - `row` = `col` = 0.
- **Latency.** Exactly 1 cycle: pixel accepted at edge N, then window and `win_vld_o` are registered and visible after edge N. They drop after edge N+1 unless another qualifying pixel was accepted at N+1.
- **Throughput.** 1 pixel/cycle sustained, and 1 window/cycle in steady state within a row.
- **Hold behaviour.** `win_o` holds its last value while `win_vld_o` = 0.
- **Frame done.** `frame_done_o` is asserted in the same cycle as `win_vld_o` for the window of pixel (IMG_H−1, IMG_W−1).
- **Reset priority.** `rst_n` low overrides a simultaneous `pix_vld_i`; that pixel is dropped.

## Configuration
- `CONV_WIN_STRIDE2_EN`
  - **Defined:** a window is emitted only when (row−2) and (col−2) are both even. That is floor((IMG_H−1)/2)*floor((IMG_W−1)/2) windows per frame.
    - `frame_done_o` pulses on the last emitted window.
    - If (IMG_H−1, IMG_W−1) does not qualify, `frame_done_o` pulses alone with `win_vld_o` = 0, one cycle after that last pixel.
  - **Undefined:** stride 1 as above. Line buffers and latency are unchanged in both modes.

## Test plan
- **Basic 4x4 frame.** IMG_W=IMG_H=4, pixels 1..16 on back-to-back cycles.
  - Exactly 4 windows.
  - First window is {1,2,3,5,6,7,9,10,11}, one cycle after pixel 11.
  - Last window is {6,7,8,10,11,12,14,15,16}, with `frame_done_o`=1.
- **Bubbles.** Same frame with `pix_vld_i` low on random cycles (about 50%).
  - Identical 4 windows in order.
  - Each window appears 1 cycle after its pixel.
  - No `win_vld_o` during gaps.
- **Back-to-back frames.** Two 4x4 frames with no gap, second frame = pixels 101..116.
  - 8 windows in total.
  - Second frame's first window is {101,102,103,105,106,107,109,110,111`}`, with no stale data from frame 1.
- **Reset mid-frame.** Assert `rst_n`=0 for 1 cycle after pixel 10, then send a fresh 16-pixel frame 1..16.
  - No window until the new pixel 11.
  - All outputs are 0 during reset.
- **Stride 2.** With `CONV_WIN_STRIDE2_EN`, IMG_W=IMG_H=6, pixels 1..36.
  - Windows only at (2,2), (2,4), (4,2), (4,4).
  - First is {1,2,3,7,8,9,13,14,15}.
  - `frame_done_o` pulses alone one cycle after pixel 36.
- **Width.** IMG_W=28, IMG_H=28, random pixels, compared against a software model: 676 windows, all bit-exact, and the pixel 0xFF passes unaltered.
